// File: rtl/uart_host_pkg.sv
// Shared definitions for the UART host sequencer.
//   - protocol command codes (echo, write RAM1-3, read RAM1-3, LED pulse)
//   - response status encoding reported with resp_done
//   - sequencer state encoding
//   - command-class decode helpers, including the BAD_CMD decode
package uart_host_pkg;

  localparam logic [7:0] CMD_ECHO = 8'd0;
  localparam logic [7:0] CMD_WR1  = 8'd1;
  localparam logic [7:0] CMD_WR3  = 8'd3;
  localparam logic [7:0] CMD_RD1  = 8'd4;
  localparam logic [7:0] CMD_RD3  = 8'd6;
  localparam logic [7:0] CMD_LED  = 8'd15;

  typedef enum logic [1:0] {
    ST_OK            = 2'd0,
    ST_BAD_CMD       = 2'd1,
    ST_ECHO_MISMATCH = 2'd2,
    ST_TIMEOUT       = 2'd3
  } resp_status_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD_TX,
    S_CMD_GAP,
    S_FETCH,
    S_FETCH_WAIT,
    S_DATA_TX,
    S_DATA_GAP,
    S_RECV,
    S_DONE
  } state_t;

  // Codes 7..14 and everything above 15 are not part of the protocol.
  function automatic logic is_bad_cmd(input logic [7:0] code);
    return !((code <= CMD_RD3) || (code == CMD_LED));
  endfunction

  function automatic logic is_write_cmd(input logic [7:0] code);
    return (code >= CMD_WR1) && (code <= CMD_WR3);
  endfunction

  function automatic logic is_read_cmd(input logic [7:0] code);
    return (code >= CMD_RD1) && (code <= CMD_RD3);
  endfunction

endpackage

// File: rtl/uart_host_sequencer_if.sv
// Bus bundle between the UART host sequencer and its surroundings.
//   cmd_valid/cmd_code/cmd_ready   command request handshake
//   resp_done/resp_status          command completion pulse and result
//   tx_data/tx_start/tx_busy       UART transmitter byte interface
//   rx_data/rx_ready               UART receiver byte interface
//   src_addr/src_data              source RAM read port (1-cycle read latency)
//   dst_addr/dst_data/dst_we       sink RAM write port
// master: the sequencer side. slave: the controller/UART/RAM side.
interface uart_host_sequencer_if #(
  parameter int ADDR_W = 10
);
  logic              cmd_valid;
  logic [7:0]        cmd_code;
  logic              cmd_ready;
  logic              resp_done;
  logic [1:0]        resp_status;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic [ADDR_W-1:0] src_addr;
  logic [7:0]        src_data;
  logic [ADDR_W-1:0] dst_addr;
  logic [7:0]        dst_data;
  logic              dst_we;

  modport master (
    input  cmd_valid, cmd_code, tx_busy, rx_data, rx_ready, src_data,
    output cmd_ready, resp_done, resp_status, tx_data, tx_start,
           src_addr, dst_addr, dst_data, dst_we
  );

  modport slave (
    output cmd_valid, cmd_code, tx_busy, rx_data, rx_ready, src_data,
    input  cmd_ready, resp_done, resp_status, tx_data, tx_start,
           src_addr, dst_addr, dst_data, dst_we
  );
endinterface

// File: rtl/uart_host_timeout.sv
// Reply inactivity timer for the UART host sequencer.
//   clk, rst  clock and asynchronous active-high reset
//   load      reload the counter with TIMEOUT_CYC
//   dec       count down this cycle (sequencer is waiting for reply bytes)
//   expired   counter has reached zero while counting is enabled
module uart_host_timeout
  import uart_host_pkg::*;
#(
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= CNT_W'(TIMEOUT_CYC);
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  // The sequencer gives a same-cycle rx byte priority over this flag.
  assign expired = dec && (cnt_reg == '0);

endmodule

// File: rtl/uart_host_sequencer.sv
// Host-side initiator for the board UART command protocol.
// Accepts one command, sends its code byte to the UART transmitter, then
// either streams XFER_LEN bytes from the source RAM (write), captures
// XFER_LEN reply bytes into the sink RAM (read), checks a one-byte echo
// reply, or finishes straight away (LED, bad code).
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   bus        uart_host_sequencer_if.master (command, response, UART TX/RX,
//              source RAM read port, sink RAM write port)
// Build option: define UART_HOST_TIMEOUT_EN to abort a reply that stalls for
// TIMEOUT_CYC cycles with status TIMEOUT; otherwise replies are awaited
// indefinitely.
module uart_host_sequencer
  import uart_host_pkg::*;
#(
  parameter int XFER_LEN    = 1024,
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_host_sequencer_if.master bus
);

  // The counter is one bit wider than the address so a full 2**ADDR_W
  // transfer can reach its end value without wrapping.
  localparam logic [ADDR_W:0] XFER_END = (ADDR_W + 1)'(XFER_LEN);
  localparam logic [ADDR_W:0] XFER_LAST = (ADDR_W + 1)'(XFER_LEN - 1);

  state_t            state_reg, state_next;
  logic [7:0]        code_reg, code_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic [7:0]        byte_reg, byte_next;
  logic [7:0]        tx_data_reg, tx_data_next;
  logic              tx_start_reg, tx_start_next;
  resp_status_t      status_reg, status_next;
  logic [ADDR_W-1:0] src_addr_reg, src_addr_next;
  logic [ADDR_W-1:0] dst_addr_reg, dst_addr_next;
  logic [7:0]        dst_data_reg, dst_data_next;
  logic              dst_we_reg, dst_we_next;
  logic              tmo_expired;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_reg     <= '0;
      count_reg    <= '0;
      byte_reg     <= '0;
      tx_data_reg  <= '0;
      tx_start_reg <= 1'b0;
      status_reg   <= ST_OK;
      src_addr_reg <= '0;
      dst_addr_reg <= '0;
      dst_data_reg <= '0;
      dst_we_reg   <= 1'b0;
    end else begin
      code_reg     <= code_next;
      count_reg    <= count_next;
      byte_reg     <= byte_next;
      tx_data_reg  <= tx_data_next;
      tx_start_reg <= tx_start_next;
      status_reg   <= status_next;
      src_addr_reg <= src_addr_next;
      dst_addr_reg <= dst_addr_next;
      dst_data_reg <= dst_data_next;
      dst_we_reg   <= dst_we_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    code_next     = code_reg;
    count_next    = count_reg;
    byte_next     = byte_reg;
    tx_data_next  = tx_data_reg;
    tx_start_next = 1'b0;
    status_next   = status_reg;
    src_addr_next = src_addr_reg;
    dst_addr_next = dst_addr_reg;
    dst_data_next = dst_data_reg;
    dst_we_next   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          code_next  = bus.cmd_code;
          count_next = '0;
          if (is_bad_cmd(bus.cmd_code)) begin
            status_next = ST_BAD_CMD;
            state_next  = S_DONE;
          end else begin
            state_next = S_CMD_TX;
          end
        end
      end

      S_CMD_TX: begin
        if (!bus.tx_busy) begin
          tx_data_next  = code_reg;
          tx_start_next = 1'b1;
          state_next    = S_CMD_GAP;
        end
      end

      // tx_busy may not yet reflect the start issued last cycle.
      S_CMD_GAP: begin
        if (is_write_cmd(code_reg)) begin
          src_addr_next = count_reg[ADDR_W-1:0];
          state_next    = S_FETCH;
        end else if ((code_reg == CMD_ECHO) || is_read_cmd(code_reg)) begin
          state_next = S_RECV;
        end else begin
          status_next = ST_OK;
          state_next  = S_DONE;
        end
      end

      // Address is on the RAM port this cycle; data appears next cycle.
      S_FETCH: begin
        state_next = S_FETCH_WAIT;
      end

      S_FETCH_WAIT: begin
        byte_next  = bus.src_data;
        state_next = S_DATA_TX;
      end

      S_DATA_TX: begin
        if (!bus.tx_busy) begin
          tx_data_next  = byte_reg;
          tx_start_next = 1'b1;
          count_next    = count_reg + (ADDR_W + 1)'(1);
          state_next    = S_DATA_GAP;
        end
      end

      // count already points past the byte just sent.
      S_DATA_GAP: begin
        if (count_reg == XFER_END) begin
          status_next = ST_OK;
          state_next  = S_DONE;
        end else begin
          src_addr_next = count_reg[ADDR_W-1:0];
          state_next    = S_FETCH;
        end
      end

      S_RECV: begin
        if (bus.rx_ready) begin
          if (code_reg == CMD_ECHO) begin
            status_next = (bus.rx_data == 8'h00) ? ST_OK : ST_ECHO_MISMATCH;
            state_next  = S_DONE;
          end else begin
            dst_we_next   = 1'b1;
            dst_addr_next = count_reg[ADDR_W-1:0];
            dst_data_next = bus.rx_data;
            count_next    = count_reg + (ADDR_W + 1)'(1);
            if (count_reg == XFER_LAST) begin
              status_next = ST_OK;
              state_next  = S_DONE;
            end
          end
        end else if (tmo_expired) begin
          status_next = ST_TIMEOUT;
          state_next  = S_DONE;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

`ifdef UART_HOST_TIMEOUT_EN
  logic tmo_load;
  logic tmo_dec;

  assign tmo_dec  = (state_reg == S_RECV);
  assign tmo_load = ((state_reg == S_CMD_GAP) && (state_next == S_RECV)) ||
                    (tmo_dec && bus.rx_ready);

  uart_host_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .load    (tmo_load),
    .dec     (tmo_dec),
    .expired (tmo_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign tmo_expired        = 1'b0;
`endif

  assign bus.cmd_ready   = (state_reg == S_IDLE);
  assign bus.resp_done   = (state_reg == S_DONE);
  assign bus.resp_status = status_reg;
  assign bus.tx_data     = tx_data_reg;
  assign bus.tx_start    = tx_start_reg;
  assign bus.src_addr    = src_addr_reg;
  assign bus.dst_addr    = dst_addr_reg;
  assign bus.dst_data    = dst_data_reg;
  assign bus.dst_we      = dst_we_reg;

endmodule
